// File: rtl/pdp8_iot_ctl_pkg.sv
// Shared PDP-8 definitions: major-state codes, the processor's own IOT
// device code and the device-00 function codes.
package pdp8_defs;

    // CPU major states; any other 4-bit code is a non-fetch state.
    localparam logic [3:0] ST_F0 = 4'd0;
    localparam logic [3:0] ST_F1 = 4'd1;
    localparam logic [3:0] ST_F2 = 4'd2;
    localparam logic [3:0] ST_F3 = 4'd3;

    // Device code whose IOTs are executed inside the processor.
    localparam logic [5:0] CPU_DEV = 6'o00;

    // Function field of a device-00 IOT (mb[2:0]).
    typedef enum logic [2:0] {
        FN_SKON = 3'd0,
        FN_ION  = 3'd1,
        FN_IOF  = 3'd2,
        FN_SRQ  = 3'd3,
        FN_NOP4 = 3'd4,
        FN_NOP5 = 3'd5,
        FN_NOP6 = 3'd6,
        FN_CAF  = 3'd7
    } iot_fn_e;

endpackage : pdp8_defs

// File: rtl/pdp8_iot_ctl.sv
// CPU-side IOT initiator and interrupt controller. Broadcasts the device
// code, executes device-00 IOTs, registers the device skip in F1 and makes
// the interrupt-take decision on the first clock of F3.
module pdp8_iot_ctl
    import pdp8_defs::*;
#(
    parameter logic [5:0] CPU_DEV    = pdp8_defs::CPU_DEV,
    parameter int         ION_DELAY  = 1,
    parameter int         NODEV_SKIP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic        iot,
    input  logic [11:0] mb,
    input  logic        io_selected,
    input  logic        io_skip,
    input  logic        io_interrupt,
    input  logic        int_inhibit,
    output logic [5:0]  io_select,
    output logic        io_clear,
    output logic        cpu_skip,
    output logic        ion,
    output logic        int_take,
    output logic        nodev
);

    logic       ion_q,      ion_d;
    logic       ion_dly_q,  ion_dly_d;
    logic       skip_q,     skip_d;
    logic       clear_q,    clear_d;
    logic       take_q,     take_d;
    logic       nodev_q,    nodev_d;
    logic [3:0] state_q;

    logic       is_cpu_dev;
    logic       f3_first;
    logic       int_cond;
    iot_fn_e    fn;

    // Opcode bits are decoded by the CPU; only device and function matter here.
    logic       unused_opcode;
    assign unused_opcode = ^mb[11:9];

    // Device code goes to the bus unconditionally; devices qualify it with F1 && iot.
    assign io_select = mb[8:3];

    assign is_cpu_dev = (mb[8:3] == CPU_DEV);
    assign fn         = iot_fn_e'(mb[2:0]);
    assign f3_first   = (state == ST_F3) && (state_q != ST_F3);
    assign int_cond   = ion_q && !ion_dly_q && io_interrupt && !int_inhibit;

    // Next-state decode for flags, registered skip and one-clock pulses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        ion_d     = ion_q;
        ion_dly_d = ion_dly_q;
        skip_d    = skip_q;
        clear_d   = 1'b0;
        take_d    = 1'b0;
        nodev_d   = 1'b0;

        if (state == ST_F0) begin
            skip_d = 1'b0;
        end

        if (state == ST_F1) begin
            skip_d = 1'b0;
            if (iot) begin
                if (is_cpu_dev) begin
                    unique case (fn)
                        FN_SKON: begin
                            skip_d    = ion_q;
                            ion_d     = 1'b0;
                            ion_dly_d = 1'b0;
                        end
                        FN_ION: begin
                            ion_d     = 1'b1;
                            ion_dly_d = (ION_DELAY != 0);
                        end
                        FN_IOF: begin
                            ion_d     = 1'b0;
                            ion_dly_d = 1'b0;
                        end
                        FN_SRQ: begin
                            skip_d = io_interrupt;
                        end
                        FN_CAF: begin
                            ion_d     = 1'b0;
                            ion_dly_d = 1'b0;
                            clear_d   = 1'b1;
                        end
                        FN_NOP4, FN_NOP5, FN_NOP6: begin
                        end
                    endcase
                end else begin
                    skip_d = io_skip;
                    if (!io_selected) begin
                        nodev_d = 1'b1;
                        skip_d  = (NODEV_SKIP != 0);
                    end
                end
            end
        end

        // End-of-instruction decision, only on the first clock of a long F3.
        if (f3_first) begin
            if (int_cond) begin
                take_d    = 1'b1;
                ion_d     = 1'b0;
                ion_dly_d = 1'b0;
            end else if (ion_dly_q) begin
                ion_dly_d = 1'b0;
            end
        end
    end

    // State register for flags, pulses and the previous major state.
    // NOTE: asynchronous reset clears everything at once, so a reset that
    // lands mid-instruction cannot leave a pulse or skip behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ion_q     <= 1'b0;
            ion_dly_q <= 1'b0;
            skip_q    <= 1'b0;
            clear_q   <= 1'b0;
            take_q    <= 1'b0;
            nodev_q   <= 1'b0;
            state_q   <= ST_F0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            ion_q     <= ion_d;
            ion_dly_q <= ion_dly_d;
            skip_q    <= skip_d;
            clear_q   <= clear_d;
            take_q    <= take_d;
            nodev_q   <= nodev_d;
            state_q   <= state;
        end
    end

    assign ion      = ion_q;
    assign cpu_skip = skip_q;
    assign io_clear = clear_q;
    assign int_take = take_q;
    assign nodev    = nodev_q;

endmodule : pdp8_iot_ctl

// File: tb/tb_pdp8_iot_ctl.sv
// Self-checking bench for pdp8_iot_ctl: directed scenarios followed by random
// instruction streams, compared against an instruction-level model.
module tb_pdp8_iot_ctl;
    import pdp8_defs::*;

    logic        clk;
    logic        reset;
    logic [3:0]  state;
    logic        iot;
    logic [11:0] mb;
    logic        io_selected;
    logic        io_skip;
    logic        io_interrupt;
    logic        int_inhibit;
    logic [5:0]  io_select;
    logic        io_clear;
    logic        cpu_skip;
    logic        ion;
    logic        int_take;
    logic        nodev;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction-level model: interrupts enabled, and "an ION happened in
    // this instruction, so its own end must not take an interrupt".
    bit m_ion;
    bit m_ion_this_instr;
    bit m_skip;

    pdp8_iot_ctl #(
        .CPU_DEV    (6'o00),
        .ION_DELAY  (1),
        .NODEV_SKIP (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .iot          (iot),
        .mb           (mb),
        .io_selected  (io_selected),
        .io_skip      (io_skip),
        .io_interrupt (io_interrupt),
        .int_inhibit  (int_inhibit),
        .io_select    (io_select),
        .io_clear     (io_clear),
        .cpu_skip     (cpu_skip),
        .ion          (ion),
        .int_take     (int_take),
        .nodev        (nodev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are examined 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_f0();
        state = ST_F0; iot = 1'b0;
        tick();
        m_skip = 1'b0;
        check("f0_skip", cpu_skip, m_skip);
        check("f0_take", int_take, 0);
        check("f0_ion", ion, m_ion);
    endtask

    task automatic do_f1(input bit is_iot, input logic [11:0] word, input bit sel,
                         input bit skp, input bit irq);
        logic [5:0] dev;
        logic [2:0] f;
        bit         e_nodev;
        bit         e_clr;
        dev = word[8:3];
        f   = word[2:0];
        state = ST_F1; iot = is_iot; mb = word;
        io_selected = sel; io_skip = skp; io_interrupt = irq;
        #1;
        check("f1_io_select", io_select, dev);
        e_nodev = 0; e_clr = 0; m_skip = 0;
        if (is_iot) begin
            if (dev == 6'o00) begin
                if (f == 3'd0) begin m_skip = m_ion; m_ion = 0; m_ion_this_instr = 0; end
                if (f == 3'd1) begin m_ion = 1; m_ion_this_instr = 1; end
                if (f == 3'd2) begin m_ion = 0; m_ion_this_instr = 0; end
                if (f == 3'd3) m_skip = irq;
                if (f == 3'd7) begin m_ion = 0; m_ion_this_instr = 0; e_clr = 1; end
            end else if (!sel) begin
                e_nodev = 1;
                m_skip  = 0;
            end else begin
                m_skip = skp;
            end
        end
        tick();
        check("f1_skip", cpu_skip, m_skip);
        check("f1_nodev", nodev, e_nodev);
        check("f1_clear", io_clear, e_clr);
        check("f1_ion", ion, m_ion);
        check("f1_take", int_take, 0);
    endtask

    task automatic do_f2(input bit irq);
        state = ST_F2; iot = $urandom_range(0, 1); io_interrupt = irq;
        io_selected = $urandom_range(0, 1); io_skip = $urandom_range(0, 1);
        tick();
        check("f2_skip", cpu_skip, m_skip);
        check("f2_nodev", nodev, 0);
        check("f2_clear", io_clear, 0);
    endtask

    task automatic do_f3(input bit irq, input bit inh, input int len);
        bit take;
        state = ST_F3; io_interrupt = irq; int_inhibit = inh;
        take = m_ion && !m_ion_this_instr && irq && !inh;
        if (take) m_ion = 0;
        m_ion_this_instr = 0;
        tick();
        check("f3_take", int_take, take);
        check("f3_ion", ion, m_ion);
        check("f3_skip", cpu_skip, m_skip);
        // Later F3 clocks must not decide again, even with a clean request.
        for (int i = 1; i < len; i++) begin
            io_interrupt = 1'b1; int_inhibit = 1'b0;
            tick();
            check("f3_hold_take", int_take, 0);
            check("f3_hold_ion", ion, m_ion);
        end
        int_inhibit = 1'b0;
    endtask

    task automatic run_instr(input bit is_iot, input logic [11:0] word, input bit sel,
                             input bit skp, input bit irq_f1, input bit irq_f3,
                             input bit inh, input int f3_len);
        do_f0();
        do_f1(is_iot, word, sel, skp, irq_f1);
        do_f2(irq_f3);
        do_f3(irq_f3, inh, f3_len);
    endtask

    initial begin
        reset = 1'b1; state = ST_F0; iot = 1'b0; mb = '0;
        io_selected = 1'b0; io_skip = 1'b0; io_interrupt = 1'b0; int_inhibit = 1'b0;
        m_ion = 0; m_ion_this_instr = 0; m_skip = 0;
        #12;
        check("rst_ion", ion, 0);
        check("rst_skip", cpu_skip, 0);
        check("rst_take", int_take, 0);
        check("rst_clear", io_clear, 0);
        check("rst_nodev", nodev, 0);
        @(negedge clk);
        reset = 1'b0;

        // ION with a request already pending: held off one instruction.
        run_instr(1, 12'o6001, 0, 0, 1, 1, 0, 1);
        run_instr(0, 12'o1234, 0, 0, 1, 1, 0, 1);
        check("ion_after_take", ion, 0);

        // SRQ with ion clear, then SKON with ion set.
        run_instr(1, 12'o6003, 0, 0, 1, 0, 0, 2);
        run_instr(1, 12'o6001, 0, 0, 0, 0, 0, 1);
        run_instr(1, 12'o6000, 0, 0, 0, 0, 0, 1);

        // Clock flag skip on a selected device, then an unselected device.
        run_instr(1, 12'o6133, 1, 1, 0, 0, 0, 1);
        run_instr(1, 12'o6453, 0, 1, 0, 0, 0, 1);

        // CAF with interrupts enabled and a request present.
        run_instr(1, 12'o6001, 0, 0, 0, 0, 0, 1);
        run_instr(0, 12'o7000, 0, 0, 0, 0, 0, 1);
        run_instr(1, 12'o6007, 0, 0, 1, 1, 0, 1);

        // Inhibit holds off a request; next instruction takes it.
        run_instr(1, 12'o6001, 0, 0, 0, 0, 0, 1);
        run_instr(0, 12'o7000, 0, 0, 1, 1, 1, 2);
        check("inh_ion_kept", ion, 1);
        run_instr(0, 12'o7000, 0, 0, 1, 1, 0, 1);

        // Reset arriving mid-F2 with ion and cpu_skip both set.
        run_instr(1, 12'o6001, 0, 0, 0, 0, 0, 1);
        do_f0();
        do_f1(1, 12'o6003, 0, 0, 1);
        check("pre_rst_skip", cpu_skip, 1);
        check("pre_rst_ion", ion, 1);
        state = ST_F2;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ion", ion, 0);
        check("mid_rst_skip", cpu_skip, 0);
        check("mid_rst_take", int_take, 0);
        m_ion = 0; m_ion_this_instr = 0; m_skip = 0;
        @(negedge clk);
        reset = 1'b0;
        do_f3(1, 0, 2);

        // Random instruction stream.
        for (int n = 0; n < 400; n++) begin
            bit          r_iot;
            logic [11:0] w;
            r_iot = ($urandom_range(0, 9) < 7);
            w = 12'($urandom);
            if ($urandom_range(0, 1) == 1) w[8:3] = 6'o00;
            run_instr(r_iot, w, ($urandom_range(0, 4) != 0), 1'($urandom),
                      1'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                      $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pdp8_iot_ctl

// File: doc/pdp8_iot_ctl.md
Name: pdp8_iot_ctl

Overview:
CPU-side IOT initiator and interrupt controller. It is the counterpart of the responder peripherals (KW8/I clock, TTY, RF disk) that answer io_select and drive io_selected, io_skip and io_interrupt.
- Broadcasts the device code and function bits of each IOT.
- Executes the processor IOTs (device 00) internally.
- Samples device responses in F1 and presents a registered skip to the PC logic.
- Owns the ION flag, the one-instruction ION delay and the interrupt-take decision at the end of each instruction (F3).

Parameters:
CPU_DEV, 6'o00, device code handled internally (SKON/ION/IOF/SRQ/CAF).
ION_DELAY, 1, 1 = interrupts are first honoured at the F3 of the instruction after ION; 0 = honoured at the ION instruction's own F3.
NODEV_SKIP, 0, 1 = an IOT that no device selects forces a skip (debug aid).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
state  input  4  CPU major state (F0=0, F1=1, F2=2, F3=3; other codes are non-fetch states)
iot  input  1  current instruction is an IOT (opcode 6)
mb  input  12  instruction word; [8:3] = device, [2:0] = function
io_selected  input  1  OR of all device select responses
io_skip  input  1  OR of all device skip responses
io_interrupt  input  1  OR of all device interrupt requests
int_inhibit  input  1  external interrupt inhibit (e.g. memory-extension pending)
io_select  output  6  device code broadcast to the bus
io_clear  output  1  one-clock bus clear pulse (CAF)
cpu_skip  output  1  registered skip to the PC increment logic
ion  output  1  interrupt-enable flag
int_take  output  1  one-clock pulse: CPU enters the interrupt sequence
nodev  output  1  one-clock pulse: IOT to an unselected device

Behaviour:
Bus broadcast
- io_select = mb[8:3], combinational, at all times.
- Devices sample it only while state==F1 && iot.

Reset values
- ion, ion_dly, cpu_skip, io_clear, int_take, nodev all 0.
- Reset is asynchronous and may arrive mid-instruction. State is cleared immediately and no pulse is emitted afterwards.

F1 with iot, device == CPU_DEV (io_selected is ignored)
- fn 0 SKON: skip if ion; then ion<=0, ion_dly<=0.
- fn 1 ION: ion<=1; ion_dly<=ION_DELAY.
- fn 2 IOF: ion<=0, ion_dly<=0.
- fn 3 SRQ: skip if io_interrupt.
- fn 7 CAF: ion<=0, ion_dly<=0; io_clear high for exactly the next clock.
- fn 4, 5, 6: no operation, no skip.

F1 with iot, other device
- cpu_skip <= io_skip.
- If io_selected==0: nodev pulses for the next clock, and cpu_skip <= NODEV_SKIP.

cpu_skip timing
- Registered at the end of the F1 cycle.
- Held through F2 and F3.
- Cleared on the next F0.
- A non-IOT F1 loads 0.

F3 (end of instruction)
- Interrupt condition: ion && !ion_dly && io_interrupt && !int_inhibit.
- When met: int_take is high for exactly one clock (registered), and ion<=0, ion_dly<=0 in the same edge.
- Otherwise, if ion_dly==1 then ion_dly<=0.
- A multi-clock F3 acts only on its first clock. This is tracked by an internal prev-state register; this is the only F3 edge detection.

Simultaneous / boundary cases
- ION, then a pending request at that instruction's F3 with ION_DELAY=1: not taken. Taken at the next instruction's F3.
- IOF, then a pending request in the same instruction: not taken.
- int_inhibit high at F3: request held off with no state change. ion and ion_dly are preserved, except that ion_dly still clears.
- io_interrupt dropping before F3: no take.
- ION while ion already set: ion_dly re-arms.
- CAF with io_interrupt high: ion is cleared, so no take.

Decomposition:
Shared package pdp8_defs, containing:
- state codes F0–F3
- CPU_DEV
- function codes FN_SKON=0, FN_ION=1, FN_IOF=2, FN_SRQ=3, FN_CAF=7

No sub-module. The block is a single always_ff for flags and pulses plus a combinational device-00 decode.

Test Plan:
- Reset mid-F2 with ion=1 and cpu_skip=1 -> all outputs 0 immediately; no int_take after release.
- IOT 6001 (ION) then a device raises io_interrupt -> no int_take at ION's F3. int_take at the next instruction's F3; ion=0 afterwards.
- io_interrupt=1, ion=0, IOT 6003 (SRQ) -> cpu_skip=1 through F2/F3, cleared at F0. IOT 6000 with ion=1 -> skip=1 and ion=0.
- IOT 6133 with io_selected=1, io_skip=1 (clock flag set) -> cpu_skip=1, nodev=0, io_select=6'o13 in F1.
- IOT 6453 with io_selected=0 -> nodev pulses for 1 clock; cpu_skip=0 (NODEV_SKIP=0).
- IOT 6007 (CAF) with ion=1 and io_interrupt=1 -> io_clear high for exactly 1 clock, ion=0, no int_take. Separately: ion=1, int_inhibit=1 at F3 -> no take; same request at the next F3 with int_inhibit=0 -> int_take.
